param_register_file: RTL and testbench

- Parametrised successor to the processor's 32x32 register file: configurable data width, depth and read-port count.
- Adds optional write-to-read bypass, a per-register pending scoreboard for pipeline hazard detection, and a multi-cycle hardware clear sequencer (one register per cycle) with a busy/done handshake.
- Sits between decode (read ports, reservations) and writeback (write port) of the pipelined RISC-V core.

---
 rtl/param_register_file.sv | 119 +++++++++++
 tb/tb_param_register_file.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// Parametrised register file with write-to-read bypass, per-register pending
// scoreboard, and a one-register-per-cycle hardware clear sequencer.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           register_write,
    input  logic [ADDR_WIDTH-1:0]          write_register,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_register,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]            read_pending,
    input  logic                           reserve_valid,
    input  logic [ADDR_WIDTH-1:0]          reserve_register,
    input  logic                           clear_request,
    output logic                           clear_busy,
    output logic                           clear_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;

    logic                  write_accept;
    logic                  reserve_accept;
    logic [ADDR_WIDTH-1:0] addr_k;

    // Traffic is only honoured in IDLE; register 0 is masked out when hardwired.
    assign write_accept   = register_write && (state == IDLE) &&
                            !((ZERO_REG != 0) && (write_register == '0));
    assign reserve_accept = reserve_valid && (state == IDLE) &&
                            !((ZERO_REG != 0) && (reserve_register == '0));

    assign clear_busy = (state == CLEAR);
    assign clear_done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear_request) state_next = CLEAR;
            CLEAR:   if (index == '1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && clear_request)
                index <= ADDR_WIDTH'(ZERO_REG);
            else if (state == CLEAR && index != '1)
                index <= index + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[index] <= '0;
        end else if (write_accept) begin
            regs[write_register] <= write_data;
        end
    end

    // Reserve is applied after the writeback clear so it wins on a collision.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (state == CLEAR) begin
            pending[index] <= 1'b0;
        end else begin
            if (write_accept)
                pending[write_register] <= 1'b0;
            if (reserve_accept)
                pending[reserve_register] <= 1'b1;
        end
    end

    always_comb begin
        read_data    = '0;
        read_pending = '0;
        addr_k       = '0;
        for (int unsigned k = 0; k < NUM_READ; k++) begin
            addr_k = read_register[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((ZERO_REG != 0) && (addr_k == '0)) begin
                read_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                read_pending[k]                       = 1'b0;
            end else if ((BYPASS != 0) && write_accept && (write_register == addr_k)) begin
                read_data[k*DATA_WIDTH +: DATA_WIDTH] = write_data;
                read_pending[k]                       = 1'b0;
            end else begin
                read_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[addr_k];
                read_pending[k]                       = pending[addr_k];
            end
        end
    end

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default 32x32 instance plus a
// 64-bit, 16-entry, 3-port instance without bypass or hardwired zero.
module tb_param_register_file;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        register_write = 1'b0;
    logic [4:0]  write_register = '0;
    logic [31:0] write_data = '0;
    logic [9:0]  read_register = '0;
    logic [63:0] read_data;
    logic [1:0]  read_pending;
    logic        reserve_valid = 1'b0;
    logic [4:0]  reserve_register = '0;
    logic        clear_request = 1'b0;
    logic        clear_busy;
    logic        clear_done;

    logic         w_reset = 1'b0;
    logic         w_register_write = 1'b0;
    logic [3:0]   w_write_register = '0;
    logic [63:0]  w_write_data = '0;
    logic [11:0]  w_read_register = '0;
    logic [191:0] w_read_data;
    logic [2:0]   w_read_pending;
    logic         w_reserve_valid = 1'b0;
    logic [3:0]   w_reserve_register = '0;
    logic         w_clear_request = 1'b0;
    logic         w_clear_busy;
    logic         w_clear_done;

    int total = 0;
    int bad   = 0;
    int busy_cnt, done_cnt, done_at;

    localparam logic [63:0] WIDE_VAL = 64'hFFFF_FFFF_0000_0001;

    always #5 clock = ~clock;

    param_register_file u_dut (
        .clock            (clock),
        .reset            (reset),
        .register_write   (register_write),
        .write_register   (write_register),
        .write_data       (write_data),
        .read_register    (read_register),
        .read_data        (read_data),
        .read_pending     (read_pending),
        .reserve_valid    (reserve_valid),
        .reserve_register (reserve_register),
        .clear_request    (clear_request),
        .clear_busy       (clear_busy),
        .clear_done       (clear_done)
    );

    param_register_file #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (4),
        .NUM_READ   (3),
        .ZERO_REG   (0),
        .BYPASS     (0)
    ) u_wide (
        .clock            (clock),
        .reset            (w_reset),
        .register_write   (w_register_write),
        .write_register   (w_write_register),
        .write_data       (w_write_data),
        .read_register    (w_read_register),
        .read_data        (w_read_data),
        .read_pending     (w_read_pending),
        .reserve_valid    (w_reserve_valid),
        .reserve_register (w_reserve_register),
        .clear_request    (w_clear_request),
        .clear_busy       (w_clear_busy),
        .clear_done       (w_clear_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        read_register = {a1, a0};
    endtask

    initial begin
        // 1. reset
        set_rd(5, 31);
        repeat (3) @(posedge clock);
        #1;
        check("rst_rd0", read_data[31:0], 0);
        check("rst_rd1", read_data[63:32], 0);
        check("rst_pend", read_pending, 0);
        check("rst_busy", clear_busy, 0);
        check("rst_done", clear_done, 0);
        reset = 1'b1;
        w_reset = 1'b1;
        step();

        // 2. write + bypass, r0 hardwired
        register_write = 1; write_register = 7; write_data = 32'hDEAD_BEEF;
        set_rd(7, 8);
        #1;
        check("bypass_r7", read_data[31:0], 32'hDEAD_BEEF);
        check("nobyp_r8", read_data[63:32], 0);
        step();
        register_write = 0;
        #1;
        check("held_r7", read_data[31:0], 32'hDEAD_BEEF);
        register_write = 1; write_register = 0; write_data = 32'h1234;
        set_rd(0, 7);
        #1;
        check("r0_same", read_data[31:0], 0);
        step();
        register_write = 0;
        #1;
        check("r0_after", read_data[31:0], 0);

        // 3. scoreboard
        reserve_valid = 1; reserve_register = 3;
        set_rd(3, 0);
        #1;
        check("pend_pre", read_pending[0], 0);
        step();
        reserve_valid = 0;
        #1;
        check("pend_r3", read_pending[0], 1);
        register_write = 1; write_register = 3; write_data = 32'h55;
        #1;
        check("pend_mask", read_pending[0], 0);
        check("byp_r3", read_data[31:0], 32'h55);
        step();
        register_write = 0;
        #1;
        check("r3_val", read_data[31:0], 32'h55);
        check("r3_pend", read_pending[0], 0);
        register_write = 1; write_register = 4; write_data = 32'h44;
        reserve_valid = 1; reserve_register = 4;
        set_rd(3, 4);
        step();
        register_write = 0; reserve_valid = 0;
        #1;
        check("r4_pend", read_pending[1], 1);
        check("r4_val", read_data[63:32], 32'h44);
        reserve_valid = 1; reserve_register = 0;
        step();
        reserve_valid = 0;
        set_rd(0, 4);
        #1;
        check("r0_nopend", read_pending[0], 0);

        // 4. preload, clear sequence
        for (int i = 1; i < 32; i++) begin
            register_write = 1; write_register = 5'(i); write_data = 32'(i);
            step();
        end
        register_write = 0;
        reserve_valid = 1; reserve_register = 10;
        step();
        reserve_valid = 0;
        set_rd(5, 10);
        #1;
        check("pre_r5", read_data[31:0], 5);
        check("pre_r10", read_data[63:32], 10);
        check("pre_p10", read_pending[1], 1);
        clear_request = 1;
        step();
        clear_request = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 5) begin
                register_write = 1; write_register = 1; write_data = 32'hABC;
                reserve_valid = 1; reserve_register = 1;
                set_rd(1, 31);
            end else begin
                register_write = 0; reserve_valid = 0;
            end
            #1;
            if (clear_busy) busy_cnt++;
            if (clear_done) begin done_cnt++; done_at = cyc; end
            if (cyc == 5) begin
                check("mid_nobyp", read_data[31:0], 0);
                check("mid_r31", read_data[63:32], 31);
            end
            step();
        end
        check("clr_busy_n", busy_cnt, 31);
        check("clr_done_n", done_cnt, 1);
        check("clr_done_at", done_at, 31);
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            #1;
            check($sformatf("clr_r%0d", a), read_data[31:0], 0);
            check($sformatf("clr_p%0d", a), read_pending[0], 0);
        end

        // 5. reset mid-clear
        register_write = 1; write_register = 20; write_data = 32'h20;
        reserve_valid = 1; reserve_register = 21;
        step();
        register_write = 0; reserve_valid = 0;
        set_rd(20, 21);
        #1;
        check("r20_pre", read_data[31:0], 32'h20);
        check("p21_pre", read_pending[1], 1);
        clear_request = 1;
        step();
        clear_request = 0;
        repeat (10) step();
        check("busy_mid", clear_busy, 1);
        reset = 0;
        #1;
        check("rstmid_busy", clear_busy, 0);
        check("rstmid_done", clear_done, 0);
        check("rstmid_r20", read_data[31:0], 0);
        check("rstmid_p21", read_pending[1], 0);
        done_cnt = 0;
        repeat (3) begin
            step();
            if (clear_done) done_cnt++;
        end
        reset = 1;
        for (int cyc = 0; cyc < 35; cyc++) begin
            step();
            if (clear_done || clear_busy) done_cnt++;
        end
        check("rst_nodone", done_cnt, 0);
        register_write = 1; write_register = 9; write_data = 32'h99;
        step();
        register_write = 0;
        set_rd(9, 9);
        #1;
        check("idle_r9", read_data[31:0], 32'h99);

        // 6. wide instance, no bypass, r0 writable
        w_read_register = '0;
        w_register_write = 1; w_write_register = 0; w_write_data = WIDE_VAL;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("w_pre%0d", k), w_read_data[k*64 +: 64], 0);
        step();
        w_register_write = 0;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("w_post%0d", k), w_read_data[k*64 +: 64], WIDE_VAL);
        w_reserve_valid = 1; w_reserve_register = 0;
        step();
        w_reserve_valid = 0;
        #1;
        check("w_pend", w_read_pending, 3'b111);
        w_register_write = 1; w_write_data = 64'h2;
        #1;
        check("w_nomask", w_read_pending, 3'b111);
        step();
        w_register_write = 0;
        #1;
        check("w_pend_clr", w_read_pending, 0);
        check("w_r0_2", w_read_data[63:0], 64'h2);
        w_clear_request = 1;
        step();
        w_clear_request = 0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (w_clear_busy) busy_cnt++;
            if (w_clear_done) begin done_cnt++; done_at = cyc; end
            step();
        end
        check("w_busy_n", busy_cnt, 16);
        check("w_done_n", done_cnt, 1);
        check("w_done_at", done_at, 16);
        check("w_r0_clr", w_read_data[63:0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
